// File: rtl/video_timing_gen.sv
// Parameterised video timing generator with optional test-pattern source.
// Define VTG_PATTERN_EN to build the pattern generator; otherwise rgb_out stays 000000.
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    output logic [23:0] rgb_out,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic [11:0] x_out,
    output logic [11:0] y_out,
    output logic        frame_start
);

    localparam logic [11:0] H_ACT        = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST       = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT        = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST       = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  r_state;
    logic [11:0] r_h;
    logic [11:0] r_v;

    logic w_running;
    logic w_hEnd;
    logic w_wrap;
    logic w_de;
    logic w_hsActive;
    logic w_vsActive;
    logic w_frameStart;

    assign w_running    = (r_state != S_IDLE);
    assign w_hEnd       = (r_h == H_LAST);
    assign w_wrap       = w_hEnd && (r_v == V_LAST);
    assign w_de         = (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hsActive   = (r_h >= H_SYNC_START) && (r_h < H_SYNC_END);
    assign w_vsActive   = (r_v >= V_SYNC_START) && (r_v < V_SYNC_END);
    assign w_frameStart = (r_h == 12'd0) && (r_v == 12'd0);

    // Dropping en only ends output at a frame wrap, so frames are never truncated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            if (!w_running) begin
                r_state <= en ? S_RUN : S_IDLE;
            end else if (en) begin
                r_state <= S_RUN;
            end else begin
                r_state <= w_wrap ? S_IDLE : S_DRAIN;
            end

            if (!w_running) begin
                r_h <= '0;
                r_v <= '0;
            end else begin
                r_h <= w_hEnd ? 12'd0 : r_h + 12'd1;
                if (w_hEnd) begin
                    r_v <= (r_v == V_LAST) ? 12'd0 : r_v + 12'd1;
                end
            end
        end
    end

`ifdef VTG_PATTERN_EN
    localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);

    logic [1:0]  r_pat;
    logic [1:0]  w_pat;
    logic [2:0]  w_barIdx;
    logic [23:0] w_rgb;

    // The selection seen at pixel (0,0) applies to that pixel and the rest of the frame.
    assign w_pat = w_frameStart ? pattern_sel : r_pat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat <= 2'd0;
        end else if (w_running && w_frameStart) begin
            r_pat <= pattern_sel;
        end
    end

    always_comb begin
        w_barIdx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (r_h >= 12'(i * BAR_W)) begin
                w_barIdx = 3'(i);
            end
        end
    end

    always_comb begin
        w_rgb = 24'h000000;
        case (w_pat)
            2'd0: begin
                case (w_barIdx)
                    3'd0:    w_rgb = 24'hFFFFFF;
                    3'd1:    w_rgb = 24'hFFFF00;
                    3'd2:    w_rgb = 24'h00FFFF;
                    3'd3:    w_rgb = 24'h00FF00;
                    3'd4:    w_rgb = 24'hFF00FF;
                    3'd5:    w_rgb = 24'hFF0000;
                    3'd6:    w_rgb = 24'h0000FF;
                    default: w_rgb = 24'h000000;
                endcase
            end
            2'd1:    w_rgb = {r_h[7:0], r_h[7:0], r_h[7:0]};
            2'd2:    w_rgb = (r_h[5] ^ r_v[5]) ? 24'h000000 : 24'hFFFFFF;
            default: w_rgb = 24'h808080;
        endcase
    end
`else
    logic w_unused;
    assign w_unused = ^pattern_sel;
`endif

    always_ff @(posedge clk) begin
        if (rst || !w_running) begin
            rgb_out     <= '0;
            de_out      <= 1'b0;
            hs_out      <= ~HS_POL;
            vs_out      <= ~VS_POL;
            x_out       <= '0;
            y_out       <= '0;
            frame_start <= 1'b0;
        end else begin
`ifdef VTG_PATTERN_EN
            rgb_out     <= w_de ? w_rgb : 24'h000000;
`else
            rgb_out     <= '0;
`endif
            de_out      <= w_de;
            hs_out      <= w_hsActive ? HS_POL : ~HS_POL;
            vs_out      <= w_vsActive ? VS_POL : ~VS_POL;
            x_out       <= r_h;
            y_out       <= r_v;
            frame_start <= w_frameStart;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen on the small 14x7 timing; follows VTG_PATTERN_EN like the DUT.
module tb_video_timing_gen;

    localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
    localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int NPIX = HT * VT;
`ifdef VTG_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  pattern_sel;
    logic [23:0] rgb_out;
    logic        de_out, hs_out, vs_out, frame_start;
    logic [11:0] x_out, y_out;

    int nComp = 0;
    int nFail = 0;
    int cyc = 0;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
        .rgb_out(rgb_out), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out),
        .x_out(x_out), .y_out(y_out), .frame_start(frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] patternColour(input logic [1:0] pat, input int x, input int y);
        int idx;
        logic [7:0] g;
        if (!PAT_EN) return 24'h000000;
        case (pat)
            2'd0: begin
                idx = x / (HA / 8);
                if (idx > 7) idx = 7;
                case (idx)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2'd1: begin
                g = 8'(x);
                return {g, g, g};
            end
            2'd2: return ((((x / 32) + (y / 32)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            default: return 24'h808080;
        endcase
    endfunction

    // Frame-level model: a linear pixel position that runs whole frames and stops only at a wrap.
    bit          mActive = 1'b0;
    int          mPos = 0;
    logic [1:0]  mPat = 2'd0;
    logic        eDe = 1'b0, eHs = 1'b0, eVs = 1'b0, eFs = 1'b0;
    logic [23:0] eRgb = 24'h0;
    int          eX = 0, eY = 0;

    always @(posedge clk) begin
        int h, v;
        logic [1:0] pat;
        if (rst || !mActive) begin
            eDe = 1'b0; eHs = 1'b0; eVs = 1'b0; eFs = 1'b0;
            eRgb = 24'h0; eX = 0; eY = 0;
        end else begin
            h = mPos % HT;
            v = mPos / HT;
            pat = (mPos == 0) ? pattern_sel : mPat;
            eDe = (h < HA) && (v < VA);
            eHs = (h >= HA + HF) && (h < HA + HF + HSW);
            eVs = (v >= VA + VF) && (v < VA + VF + VSW);
            eFs = (mPos == 0);
            eX = h;
            eY = v;
            eRgb = eDe ? patternColour(pat, h, v) : 24'h0;
        end
        if (rst) begin
            mActive = 1'b0; mPos = 0; mPat = 2'd0;
        end else if (!mActive) begin
            mActive = en; mPos = 0;
        end else begin
            if (mPos == 0) mPat = pattern_sel;
            if (mPos == NPIX - 1) begin
                mPos = 0;
                mActive = en;
            end else begin
                mPos = mPos + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
        nComp++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model_de", 24'(de_out), 24'(eDe));
        checkOutput("model_hs", 24'(hs_out), 24'(eHs));
        checkOutput("model_vs", 24'(vs_out), 24'(eVs));
        checkOutput("model_fs", 24'(frame_start), 24'(eFs));
        checkOutput("model_rgb", rgb_out, eRgb);
        if (eDe) begin
            checkOutput("model_x", 24'(x_out), 24'(eX));
            checkOutput("model_y", 24'(y_out), 24'(eY));
        end
    end

    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] sel, input int n);
        rst = r;
        en = e;
        pattern_sel = sel;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; pattern_sel = 2'd1;
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 2'd1, 1);
        checkOutput("reset_de", 24'(de_out), 24'h0);
        checkOutput("reset_hs", 24'(hs_out), 24'h0);
        checkOutput("reset_vs", 24'(vs_out), 24'h0);
        checkOutput("reset_rgb", rgb_out, 24'h0);

        // Frame 1: ramp pattern; start two negedges after en rises
        applyStimulus(1'b0, 1'b1, 2'd1, 2);
        checkOutput("f1_fs", 24'(frame_start), 24'h1);
        checkOutput("f1_de", 24'(de_out), 24'h1);
        checkOutput("f1_x0", 24'(x_out), 24'h0);
        checkOutput("f1_y0", 24'(y_out), 24'h0);
        applyStimulus(1'b0, 1'b1, 2'd1, 3);
        checkOutput("ramp_x3", rgb_out, PAT_EN ? 24'h030303 : 24'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, 4);
        checkOutput("ramp_x7_after_sel", rgb_out, PAT_EN ? 24'h070707 : 24'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, 91);

        // Frame 2: bars, offset 0 is exactly 98 clocks after frame 1 start
        checkOutput("f2_fs_period", 24'(frame_start), 24'h1);
        applyStimulus(1'b0, 1'b1, 2'd0, 1);
        checkOutput("bar_x1", rgb_out, PAT_EN ? 24'hFFFF00 : 24'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, 4);
        checkOutput("bar_x5", rgb_out, PAT_EN ? 24'hFF0000 : 24'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, 1);
        checkOutput("bar_x6", rgb_out, PAT_EN ? 24'h0000FF : 24'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, 3);
        checkOutput("hs_h9", 24'(hs_out), 24'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, 1);
        checkOutput("hs_h10", 24'(hs_out), 24'h1);
        applyStimulus(1'b0, 1'b1, 2'd0, 1);
        checkOutput("hs_h11", 24'(hs_out), 24'h1);
        applyStimulus(1'b0, 1'b1, 2'd0, 1);
        checkOutput("hs_h12", 24'(hs_out), 24'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, 57);
        checkOutput("vs_line4_end", 24'(vs_out), 24'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, 1);
        checkOutput("vs_line5_start", 24'(vs_out), 24'h1);
        applyStimulus(1'b0, 1'b1, 2'd0, 13);
        checkOutput("vs_line5_end", 24'(vs_out), 24'h1);
        applyStimulus(1'b0, 1'b1, 2'd0, 1);
        checkOutput("vs_line6", 24'(vs_out), 24'h0);
        applyStimulus(1'b0, 1'b1, 2'd0, 14);

        // Frame 3: drop en while counters sit at v=1, h=3
        checkOutput("f3_fs", 24'(frame_start), 24'h1);
        applyStimulus(1'b0, 1'b1, 2'd0, 16);
        applyStimulus(1'b0, 1'b0, 2'd0, 33);
        checkOutput("drain_last_de", 24'(de_out), 24'h1);
        checkOutput("drain_last_x", 24'(x_out), 24'd7);
        checkOutput("drain_last_y", 24'(y_out), 24'd3);
        applyStimulus(1'b0, 1'b0, 2'd0, 1);
        checkOutput("drain_after_de", 24'(de_out), 24'h0);
        applyStimulus(1'b0, 1'b0, 2'd0, 48);
        checkOutput("idle_no_fs", 24'(frame_start), 24'h0);
        checkOutput("idle_vs", 24'(vs_out), 24'h0);
        applyStimulus(1'b0, 1'b0, 2'd0, 20);

        // Restart from idle
        applyStimulus(1'b0, 1'b1, 2'd3, 2);
        checkOutput("restart_fs", 24'(frame_start), 24'h1);
        checkOutput("restart_rgb", rgb_out, PAT_EN ? 24'h808080 : 24'h0);
        applyStimulus(1'b0, 1'b1, 2'd3, 30);

        // Reset pulse mid-frame with en held
        applyStimulus(1'b1, 1'b1, 2'd2, 1);
        checkOutput("rst_de", 24'(de_out), 24'h0);
        checkOutput("rst_hs", 24'(hs_out), 24'h0);
        checkOutput("rst_vs", 24'(vs_out), 24'h0);
        checkOutput("rst_rgb", rgb_out, 24'h0);
        applyStimulus(1'b0, 1'b1, 2'd2, 2);
        checkOutput("rst_restart_fs", 24'(frame_start), 24'h1);
        checkOutput("rst_restart_x", 24'(x_out), 24'h0);
        checkOutput("checker_00", rgb_out, PAT_EN ? 24'hFFFFFF : 24'h0);
        applyStimulus(1'b0, 1'b1, 2'd2, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end

endmodule
